// File: rtl/lc3_datapath_p.sv
// Parametrised LC-3 datapath: bus, register file, ALU, address adder, architectural
// registers, CC/BEN, sticky bus-contention flag and a wait-state FSM on MDR reads.
module lc3_datapath_p #(
  parameter int unsigned DATA_W   = 16,
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              LD_MAR,
  input  logic              LD_MDR,
  input  logic              LD_IR,
  input  logic              LD_BEN,
  input  logic              LD_CC,
  input  logic              LD_REG,
  input  logic              LD_PC,
  input  logic              LD_LED,
  input  logic              GatePC,
  input  logic              GateMDR,
  input  logic              GateALU,
  input  logic              GateMARMUX,
  input  logic              SR2MUX,
  input  logic              ADDR1MUX,
  input  logic              DRMUX,
  input  logic              SR1MUX,
  input  logic              MIO_EN,
  input  logic [1:0]        PCMUX,
  input  logic [1:0]        ADDR2MUX,
  input  logic [1:0]        ALUK,
  input  logic [DATA_W-1:0] MDR_In,
  input  logic              MDR_In_valid,
  output logic              BEN,
  output logic [2:0]        CC,
  output logic [DATA_W-1:0] IR,
  output logic [DATA_W-1:0] MDR,
  output logic [DATA_W-1:0] MAR,
  output logic [DATA_W-1:0] PC,
  output logic [DATA_W-1:0] LED,
  output logic              Mem_Wait,
  output logic              Bus_Err
);

  localparam logic [DATA_W-1:0] PC_RST = DATA_W'(RESET_PC);

  typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} mdr_state_e;

  mdr_state_e        state_q, state_d;
  logic [DATA_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] mar_q, mar_d;
  logic [DATA_W-1:0] mdr_q, mdr_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic [DATA_W-1:0] led_q, led_d;
  logic [2:0]        cc_q, cc_d;
  logic              ben_q, ben_d;
  logic              bus_err_q, bus_err_d;
  logic              mem_wait_q, mem_wait_d;
  logic [DATA_W-1:0] rf_q [8];
  logic [DATA_W-1:0] rf_d [8];

  logic [15:0]       ir16;
  logic [2:0]        sr1_idx, sr2_idx, dr_idx;
  logic [DATA_W-1:0] sr1, sr2;
  logic [DATA_W-1:0] sext5, sext6, sext9, sext11;
  logic [DATA_W-1:0] addr1, addr2, adder;
  logic [DATA_W-1:0] alu_b, alu_out;
  logic [DATA_W-1:0] bus;
  logic              multi_gate;
  logic [2:0]        cc_c;

  // Instruction field decode always comes from the low 16 bits of IR.
  assign ir16    = ir_q[15:0];
  assign sr1_idx = SR1MUX ? ir16[8:6] : ir16[11:9];
  assign sr2_idx = ir16[2:0];
  assign dr_idx  = DRMUX ? 3'b111 : ir16[11:9];
  assign sr1     = rf_q[sr1_idx];
  assign sr2     = rf_q[sr2_idx];

  assign sext5  = {{(DATA_W-5){ir16[4]}},   ir16[4:0]};
  assign sext6  = {{(DATA_W-6){ir16[5]}},   ir16[5:0]};
  assign sext9  = {{(DATA_W-9){ir16[8]}},   ir16[8:0]};
  assign sext11 = {{(DATA_W-11){ir16[10]}}, ir16[10:0]};

  // Address adder.
  always_comb begin
    addr2 = '0;
    case (ADDR2MUX)
      2'b00: addr2 = '0;
      2'b01: addr2 = sext6;
      2'b10: addr2 = sext9;
      2'b11: addr2 = sext11;
      default: addr2 = '0;
    endcase
  end
  assign addr1 = ADDR1MUX ? sr1 : pc_q;
  assign adder = addr1 + addr2;

  // ALU.
  assign alu_b = SR2MUX ? sext5 : sr2;
  always_comb begin
    alu_out = '0;
    case (ALUK)
      2'b00: alu_out = sr1 + alu_b;
      2'b01: alu_out = sr1 & alu_b;
      2'b10: alu_out = ~sr1;
      2'b11: alu_out = sr1;
      default: alu_out = '0;
    endcase
  end

  // Priority bus mux; contention is any pair of gates asserted together.
  always_comb begin
    bus = '0;
    if (GatePC)          bus = pc_q;
    else if (GateMDR)    bus = mdr_q;
    else if (GateALU)    bus = alu_out;
    else if (GateMARMUX) bus = adder;
  end
  assign multi_gate = (GatePC & (GateMDR | GateALU | GateMARMUX)) |
                      (GateMDR & (GateALU | GateMARMUX)) |
                      (GateALU & GateMARMUX);

  always_comb begin
    cc_c = 3'b001;
    if (bus == '0)              cc_c = 3'b010;
    else if (bus[DATA_W-1])     cc_c = 3'b100;
  end

  // Next-state for architectural registers and the MDR wait FSM.
  always_comb begin
    pc_d      = pc_q;
    mar_d     = mar_q;
    mdr_d     = mdr_q;
    ir_d      = ir_q;
    led_d     = led_q;
    cc_d      = cc_q;
    ben_d     = ben_q;
    bus_err_d = bus_err_q | multi_gate;
    state_d   = state_q;
    rf_d      = rf_q;

    if (LD_PC) begin
      case (PCMUX)
        2'b00: pc_d = pc_q + DATA_W'(1);
        2'b01: pc_d = bus;
        2'b10: pc_d = adder;
        2'b11: pc_d = PC_RST;
        default: pc_d = pc_q;
      endcase
    end
    if (LD_MAR) mar_d = bus;
    if (LD_IR)  ir_d  = bus;
    if (LD_LED) led_d = ir_q;
    if (LD_CC)  cc_d  = cc_c;
    if (LD_BEN) ben_d = |(ir16[11:9] & cc_q);
    if (LD_REG) rf_d[dr_idx] = bus;

    case (state_q)
      S_IDLE: begin
        if (LD_MDR) begin
          if (!MIO_EN)          mdr_d   = bus;
          else if (MDR_In_valid) mdr_d  = MDR_In;
          else                  state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (MDR_In_valid) begin
          mdr_d   = MDR_In;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    mem_wait_d = (state_d == S_WAIT);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= S_IDLE;
      pc_q       <= PC_RST;
      mar_q      <= '0;
      mdr_q      <= '0;
      ir_q       <= '0;
      led_q      <= '0;
      cc_q       <= 3'b000;
      ben_q      <= 1'b0;
      bus_err_q  <= 1'b0;
      mem_wait_q <= 1'b0;
      for (int i = 0; i < 8; i++) rf_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      mar_q      <= mar_d;
      mdr_q      <= mdr_d;
      ir_q       <= ir_d;
      led_q      <= led_d;
      cc_q       <= cc_d;
      ben_q      <= ben_d;
      bus_err_q  <= bus_err_d;
      mem_wait_q <= mem_wait_d;
      rf_q       <= rf_d;
    end
  end

  assign BEN      = ben_q;
  assign CC       = cc_q;
  assign IR       = ir_q;
  assign MDR      = mdr_q;
  assign MAR      = mar_q;
  assign PC       = pc_q;
  assign LED      = led_q;
  assign Mem_Wait = mem_wait_q;
  assign Bus_Err  = bus_err_q;

endmodule

// File: tb/tb_lc3_datapath_p.sv
// Directed bench for lc3_datapath_p: a 16-bit instance (RESET_PC=3000) and a
// 32-bit instance (RESET_PC=0200) driven from the same control stream.
module tb_lc3_datapath_p;

  logic clk;
  logic reset;
  logic ld_mar, ld_mdr, ld_ir, ld_ben, ld_cc, ld_reg, ld_pc, ld_led;
  logic gate_pc, gate_mdr, gate_alu, gate_marmux;
  logic sr2mux, addr1mux, drmux, sr1mux, mio_en;
  logic [1:0] pcmux, addr2mux, aluk;
  logic [15:0] mdr_in16;
  logic [31:0] mdr_in32;
  logic mdr_in_valid;

  logic        ben16, memw16, berr16;
  logic [2:0]  cc16;
  logic [15:0] ir16, mdr16, mar16, pc16, led16;
  logic        ben32, memw32, berr32;
  logic [2:0]  cc32;
  logic [31:0] ir32, mdr32, mar32, pc32, led32;

  int n_checks = 0;
  int n_fail   = 0;

  lc3_datapath_p #(.DATA_W(16), .RESET_PC(16'h3000)) dut16 (
    .Clk(clk), .Reset(reset),
    .LD_MAR(ld_mar), .LD_MDR(ld_mdr), .LD_IR(ld_ir), .LD_BEN(ld_ben),
    .LD_CC(ld_cc), .LD_REG(ld_reg), .LD_PC(ld_pc), .LD_LED(ld_led),
    .GatePC(gate_pc), .GateMDR(gate_mdr), .GateALU(gate_alu), .GateMARMUX(gate_marmux),
    .SR2MUX(sr2mux), .ADDR1MUX(addr1mux), .DRMUX(drmux), .SR1MUX(sr1mux), .MIO_EN(mio_en),
    .PCMUX(pcmux), .ADDR2MUX(addr2mux), .ALUK(aluk),
    .MDR_In(mdr_in16), .MDR_In_valid(mdr_in_valid),
    .BEN(ben16), .CC(cc16), .IR(ir16), .MDR(mdr16), .MAR(mar16), .PC(pc16), .LED(led16),
    .Mem_Wait(memw16), .Bus_Err(berr16)
  );

  lc3_datapath_p #(.DATA_W(32), .RESET_PC(16'h0200)) dut32 (
    .Clk(clk), .Reset(reset),
    .LD_MAR(ld_mar), .LD_MDR(ld_mdr), .LD_IR(ld_ir), .LD_BEN(ld_ben),
    .LD_CC(ld_cc), .LD_REG(ld_reg), .LD_PC(ld_pc), .LD_LED(ld_led),
    .GatePC(gate_pc), .GateMDR(gate_mdr), .GateALU(gate_alu), .GateMARMUX(gate_marmux),
    .SR2MUX(sr2mux), .ADDR1MUX(addr1mux), .DRMUX(drmux), .SR1MUX(sr1mux), .MIO_EN(mio_en),
    .PCMUX(pcmux), .ADDR2MUX(addr2mux), .ALUK(aluk),
    .MDR_In(mdr_in32), .MDR_In_valid(mdr_in_valid),
    .BEN(ben32), .CC(cc32), .IR(ir32), .MDR(mdr32), .MAR(mar32), .PC(pc32), .LED(led32),
    .Mem_Wait(memw32), .Bus_Err(berr32)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ctl();
    {ld_mar, ld_mdr, ld_ir, ld_ben, ld_cc, ld_reg, ld_pc, ld_led} = '0;
    {gate_pc, gate_mdr, gate_alu, gate_marmux} = '0;
    {sr2mux, addr1mux, drmux, sr1mux, mio_en} = '0;
    pcmux = 2'b00; addr2mux = 2'b00; aluk = 2'b00;
    mdr_in_valid = 1'b0;
  endtask

  // One-cycle memory read into MDR on both instances.
  task automatic load_mdr(input logic [31:0] v);
    clear_ctl();
    mdr_in16 = v[15:0]; mdr_in32 = v;
    ld_mdr = 1'b1; mio_en = 1'b1; mdr_in_valid = 1'b1;
    step();
    clear_ctl();
  endtask

  task automatic load_ir(input logic [31:0] v);
    load_mdr(v);
    gate_mdr = 1'b1; ld_ir = 1'b1;
    step();
    clear_ctl();
  endtask

  task automatic write_reg(input logic [2:0] idx, input logic [31:0] v);
    load_ir({20'h0, idx, 9'h000});
    load_mdr(v);
    gate_mdr = 1'b1; ld_reg = 1'b1;
    step();
    clear_ctl();
  endtask

  initial begin
    clear_ctl();
    mdr_in16 = '0; mdr_in32 = '0;
    reset = 1'b1;
    #2;
    step();
    check_eq("rst_pc16", 32'(pc16), 32'h3000);
    check_eq("rst_pc32", pc32, 32'h0000_0200);
    check_eq("rst_regs16", 32'({ir16 | mdr16 | mar16 | led16}), 32'h0);
    check_eq("rst_flags16", {26'h0, ben16, cc16, memw16, berr16}, 32'h0);
    reset = 1'b0;

    gate_pc = 1'b1; ld_ir = 1'b1;
    step(); clear_ctl();
    check_eq("ir_from_pc", 32'(ir16), 32'h3000);

    write_reg(3'd1, 32'h7FFF);
    write_reg(3'd2, 32'h0001);
    load_ir(32'h1642);
    sr1mux = 1'b1; aluk = 2'b00; gate_alu = 1'b1; ld_reg = 1'b1; ld_cc = 1'b1;
    step(); clear_ctl();
    check_eq("add_cc", 32'(cc16), 32'h4);
    aluk = 2'b11; gate_alu = 1'b1; ld_mar = 1'b1;
    step(); clear_ctl();
    check_eq("r3_sum", 32'(mar16), 32'h8000);

    // Destination equals source: the ALU sees the pre-write value.
    aluk = 2'b00; sr2mux = 1'b1; gate_alu = 1'b1; ld_reg = 1'b1; ld_mar = 1'b1;
    step();
    check_eq("dr_eq_sr1_a", 32'(mar16), 32'h8002);
    step(); clear_ctl();
    check_eq("dr_eq_sr1_b", 32'(mar16), 32'h8004);
    aluk = 2'b10; gate_alu = 1'b1; ld_mar = 1'b1;
    step(); clear_ctl();
    check_eq("alu_not", 32'(mar16), 32'h7FFB);
    aluk = 2'b01; sr1mux = 1'b1; gate_alu = 1'b1; ld_mar = 1'b1;
    step(); clear_ctl();
    check_eq("alu_and", 32'(mar16), 32'h0001);
    ld_led = 1'b1;
    step(); clear_ctl();
    check_eq("led", 32'(led16), 32'h1642);

    load_ir(32'h0800);
    ld_ben = 1'b1;
    step(); clear_ctl();
    check_eq("ben_brn", 32'(ben16), 32'h1);
    ld_ben = 1'b1; ld_cc = 1'b1;
    step(); clear_ctl();
    check_eq("ben_old_cc", 32'(ben16), 32'h1);
    check_eq("cc_zero", 32'(cc16), 32'h2);
    ld_ben = 1'b1;
    step(); clear_ctl();
    check_eq("ben_new_cc", 32'(ben16), 32'h0);

    check_eq("no_bus_err", 32'(berr16), 32'h0);
    gate_pc = 1'b1; gate_alu = 1'b1; ld_mar = 1'b1;
    step(); clear_ctl();
    check_eq("contend_mar", 32'(mar16), 32'h3000);
    check_eq("bus_err_set", 32'(berr16), 32'h1);
    step(); step();
    check_eq("bus_err_hold", 32'(berr16), 32'h1);

    gate_pc = 1'b1; ld_mdr = 1'b1;
    step(); clear_ctl();
    check_eq("mdr_from_bus", 32'(mdr16), 32'h3000);

    // Stalled read: valid arrives on the fourth edge.
    mdr_in16 = 16'hABCD; mdr_in32 = 32'h0000_ABCD;
    ld_mdr = 1'b1; mio_en = 1'b1;
    step(); clear_ctl();
    check_eq("wait_c1", 32'(memw16), 32'h1);
    step();
    check_eq("wait_c2", 32'(memw16), 32'h1);
    step();
    check_eq("wait_c3", 32'(memw16), 32'h1);
    check_eq("wait_mdr_hold", 32'(mdr16), 32'h3000);
    mdr_in_valid = 1'b1;
    step(); clear_ctl();
    check_eq("wait_done", 32'(memw16), 32'h0);
    check_eq("wait_mdr", 32'(mdr16), 32'hABCD);

    ld_mdr = 1'b1; mio_en = 1'b1;
    step(); clear_ctl();
    check_eq("wait_again", 32'(memw16), 32'h1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_eq("rst_wait_mdr", 32'(mdr16), 32'h0);
    check_eq("rst_wait_memw", 32'(memw16), 32'h0);
    check_eq("rst_bus_err", 32'(berr16), 32'h0);
    mdr_in_valid = 1'b1;
    step(); clear_ctl();
    check_eq("idle_ignores_valid", 32'(mdr16), 32'h0);

    // Wide datapath: address adder and PC wrap.
    load_ir(32'h0000_01FF);
    load_mdr(32'h0000_0010);
    gate_mdr = 1'b1; pcmux = 2'b01; ld_pc = 1'b1;
    step(); clear_ctl();
    check_eq("pc32_load", pc32, 32'h0000_0010);
    addr2mux = 2'b10; addr1mux = 1'b0; gate_marmux = 1'b1; ld_mar = 1'b1;
    step();
    check_eq("adder32", mar32, 32'h0000_000F);
    check_eq("adder16", 32'(mar16), 32'h0000_000F);
    ld_mar = 1'b0; gate_marmux = 1'b0; pcmux = 2'b10; ld_pc = 1'b1;
    step(); clear_ctl();
    check_eq("pc32_adder", pc32, 32'h0000_000F);
    load_mdr(32'hFFFF_FFFF);
    gate_mdr = 1'b1; pcmux = 2'b01; ld_pc = 1'b1;
    step(); clear_ctl();
    check_eq("pc32_ones", pc32, 32'hFFFF_FFFF);
    pcmux = 2'b00; ld_pc = 1'b1;
    step(); clear_ctl();
    check_eq("pc32_wrap", pc32, 32'h0);
    check_eq("pc16_wrap", 32'(pc16), 32'h0);
    pcmux = 2'b11; ld_pc = 1'b1;
    step(); clear_ctl();
    check_eq("pc32_resetpc", pc32, 32'h0000_0200);
    check_eq("pc16_resetpc", 32'(pc16), 32'h3000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lc3_datapath_p.md
# lc3_datapath_p

Parametrised successor to the lab-5 LC-3 datapath: the same control-signal interface from the ISDU, with these changes:
- configurable data width and reset PC;
- a ready/valid handshake on memory-read data into MDR, with a wait-state FSM;
- sticky bus-contention detection;
- CC exposed to the controller.

It sits between the ISDU and the memory/IO bridge.

## Interface
- DATA_W, 16: datapath width, ≥16; IR fields always decode from IR[15:0]
- RESET_PC, 16'h0000: PC value after Reset, zero-extended to DATA_W

Ports:
- Clk  in  1  system clock, all state on rising edge
- Reset  in  1  synchronous, active-high
- LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED  in  1 each  register load enables
- GatePC, GateMDR, GateALU, GateMARMUX  in  1 each  bus drivers
- SR2MUX, ADDR1MUX, DRMUX, SR1MUX, MIO_EN  in  1 each  select lines
- PCMUX, ADDR2MUX, ALUK  in  2 each  select lines
- MDR_In  in  DATA_W  memory read data
- MDR_In_valid  in  1  MDR_In holds valid read data this cycle
- BEN  out  1  registered branch enable
- CC  out  3  registered NZP
- IR, MDR, MAR, PC, LED  out  DATA_W each  architectural registers
- Mem_Wait  out  1  MDR load outstanding; ISDU must hold state
- Bus_Err  out  1  sticky: more than one gate asserted in some cycle

## Operation
**Bus (combinational)**
- Selects PC, MDR, ALU out or MARMUX adder by gate.
- No gate asserted: bus is 0.
- Multiple gates: priority GatePC > GateMDR > GateALU > GateMARMUX; Bus_Err sets on the next edge and holds until Reset.

**Address adder:** Add1 + Add2, mod 2^DATA_W.
- Add1: ADDR1MUX 0 = PC, 1 = SR1.
- Add2: ADDR2MUX 00 = 0, 01 = sext(IR[5:0]), 10 = sext(IR[8:0]), 11 = sext(IR[10:0]).
- Every sign extension fills to DATA_W from the field MSB.

**PC next value (PCMUX)**
- 00 = PC+1, 01 = bus, 10 = adder, 11 = RESET_PC.
- PC updates only when LD_PC is high.

**Register file**
- 8 × DATA_W registers.
- SR1 index: SR1MUX 0 = IR[11:9], 1 = IR[8:6]. SR2 index: IR[2:0].
- DR: DRMUX 0 = IR[11:9], 1 = 3'b111.
- Reads are combinational. Write takes the bus on the LD_REG edge, with no write-to-read bypass.

**ALU**
- B operand: SR2MUX 0 = SR2, 1 = sext(IR[4:0]).
- ALUK 00 = A+B (mod 2^DATA_W), 01 = A&B, 10 = ~A, 11 = A.

**Registers**
- MAR ← bus on LD_MAR.
- IR ← bus on LD_IR.
- LED ← IR on LD_LED.

**Condition codes**
- CC ← on LD_CC, from the bus value: 010 if the bus is 0, 100 if bus[DATA_W-1] is set, else 001.

**BEN:** on LD_BEN, BEN ← (IR[11]&CC[2]) | (IR[10]&CC[1]) | (IR[9]&CC[0]), using the registered CC.

**MDR FSM (states IDLE, WAIT)**
- IDLE, LD_MDR & !MIO_EN: MDR ← bus; stay in IDLE.
- IDLE, LD_MDR & MIO_EN & MDR_In_valid: MDR ← MDR_In; stay in IDLE.
- IDLE, LD_MDR & MIO_EN & !MDR_In_valid: go to WAIT; MDR unchanged.
- WAIT: Mem_Wait = 1. LD_MDR and MIO_EN are ignored. The first cycle with MDR_In_valid=1 loads MDR ← MDR_In and returns to IDLE.
- Other loads (PC, REG, …) proceed normally in WAIT; the ISDU is responsible for stalling them.

## Timing
**Reset values**, applied on the first rising edge with Reset=1, and also when Reset is asserted mid-WAIT:
- PC = RESET_PC.
- MAR, MDR, IR, LED and all eight registers = 0.
- CC = 000, BEN = 0, Bus_Err = 0.
- Mem_Wait = 0; FSM in IDLE.

**Latency**
- Every load is visible one cycle after its enabled edge.
- Bus, adder, ALU and CC-compute are zero-latency combinational.
- Mem_Wait rises on the edge after the stalled LD_MDR and falls on the edge where valid is sampled; MDR updates on that same edge.
- Minimum memory read is 1 cycle (valid present with LD_MDR).

**Boundary cases**
- LD_CC and LD_BEN on the same edge: BEN uses the old CC.
- LD_REG with DR = SR1: the ALU reads the old value that cycle.
- PC+1 at all-ones wraps to 0.

## Test plan
- Reset with RESET_PC=16'h3000, DATA_W=16 → PC=3000, every other output 0, Mem_Wait=0 after one edge.
- GatePC=1, LD_IR=1, PC=3000 → IR=3000 next cycle. GatePC=GateALU=1 in one cycle → bus carries PC, Bus_Err=1 and stays 1 until Reset.
- R1=7FFF, R2=0001, IR=ADD R3,R1,R2 (16'h1642), ALUK=00, GateALU, LD_REG, LD_CC → R3=8000, CC=100. Then BRn (IR=16'h0800), LD_BEN → BEN=1.
- LD_MDR & MIO_EN with valid low for 3 cycles, then MDR_In=ABCD with valid → Mem_Wait high exactly 3 cycles, MDR=ABCD on the 4th edge. Reset asserted during WAIT → MDR=0, Mem_Wait=0.
- DATA_W=32, IR[8:0]=9'h1FF, ADDR2MUX=10, ADDR1MUX=0, PC=0000_0010 → adder=0000_000F. PCMUX=10, LD_PC → PC=0000_000F. PC=FFFF_FFFF with PCMUX=00 → PC=0.
